// File: rtl/logs_pkg.sv
// logs_pkg: shared constants, helper functions and FSM state type for the logistic-map scheduler.
package logs_pkg;

   localparam int unsigned FRAC_DEFAULT = 8;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StOffer
   } sched_state_e;

   // Reset value of every voice's x: 1/16 in 0.FRAC format.
   function automatic int unsigned x_init_of(input int unsigned frac);
      return 32'd1 << (frac - 4);
   endfunction

   // Base r: 1 + 1/16 in 2.FRAC format.
   function automatic int unsigned initial_r_of(input int unsigned frac);
      return (32'd1 << frac) | (32'd1 << (frac - 4));
   endfunction

   // r must stay below 4.0; reaching it reloads the base value.
   function automatic int unsigned r_limit_of(input int unsigned frac);
      return 32'd4 << frac;
   endfunction

endpackage

// File: rtl/logs_tick_gen.sv
// logs_tick_gen: free-running TICK_DIV counter producing a one-cycle tick, gated by enable.
module logs_tick_gen #(
   parameter int unsigned TICK_DIV = 30000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   // Counter keeps running while disabled; only the tick output is gated.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/logs_map_sched.sv
// logs_map_sched: round-robin scheduler time-sharing one logistic-map iterator across N_VOICE
// voices, offering each new x as a frequency update and sweeping r slowly between rounds.
// Build macro LOGS_SCHED_RESEED_EN: when defined, a zero iterator result is stored as X_INIT.
module logs_map_sched
   import logs_pkg::*;
#(
   parameter int unsigned N_VOICE       = 4,
   parameter int unsigned FRAC          = FRAC_DEFAULT,
   parameter int unsigned TICK_DIV      = 30000,
   parameter int unsigned MAP_LAT       = 2,
   parameter int unsigned R_STEP_ROUNDS = 16,
   parameter int unsigned R_SPREAD      = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   output logic                       map_valid,
   output logic [FRAC-1:0]            map_x,
   output logic [FRAC+1:0]            map_r,
   input  logic [FRAC-1:0]            map_next_x,
   output logic                       upd_valid,
   input  logic                       upd_ready,
   output logic [$clog2(N_VOICE)-1:0] upd_voice,
   output logic [FRAC-1:0]            upd_freq,
   output logic                       busy,
   output logic                       overrun
);

   localparam int unsigned VW  = $clog2(N_VOICE);
   localparam int unsigned RVW = FRAC + 2;
   localparam int unsigned LW  = FRAC + 3;
   localparam int unsigned WW  = $clog2(MAP_LAT + 1);
   localparam int unsigned RCW = $clog2(R_STEP_ROUNDS + 1);

   localparam logic [FRAC-1:0] X_INIT    = FRAC'(x_init_of(FRAC));
   localparam logic [RVW-1:0]  INITIAL_R = RVW'(initial_r_of(FRAC));
   localparam logic [LW-1:0]   R_LIMIT   = LW'(r_limit_of(FRAC));
   localparam logic [VW-1:0]   V_LAST    = VW'(N_VOICE - 1);
   localparam logic [WW-1:0]   W_LAST    = WW'(MAP_LAT - 1);
   localparam logic [RCW-1:0]  R_LAST    = RCW'(R_STEP_ROUNDS - 1);

   sched_state_e                      state_q, state_d;
   logic [VW-1:0]                     v_q, v_d;
   logic [WW-1:0]                     wait_q, wait_d;
   logic [RCW-1:0]                    round_q, round_d;
   logic                              pending_q, pending_d;
   logic                              overrun_q, overrun_d;
   logic [VW-1:0]                     upd_voice_q, upd_voice_d;
   logic [FRAC-1:0]                   upd_freq_q, upd_freq_d;
   logic [N_VOICE-1:0][FRAC-1:0]      x_q, x_d;
   logic [N_VOICE-1:0][RVW-1:0]       r_q, r_d;
   logic                              tick;
   logic [FRAC-1:0]                   cap;
   logic [LW-1:0]                     r_inc;

   logs_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .enable(enable),
      .tick  (tick)
   );

   // State and register files; everything clears immediately on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         v_q         <= '0;
         wait_q      <= '0;
         round_q     <= '0;
         pending_q   <= 1'b0;
         overrun_q   <= 1'b0;
         upd_voice_q <= '0;
         upd_freq_q  <= X_INIT;
         for (int unsigned i = 0; i < N_VOICE; i++) begin
            x_q[i] <= X_INIT;
            r_q[i] <= RVW'(initial_r_of(FRAC) + i * R_SPREAD);
         end
      end else begin
         state_q     <= state_d;
         v_q         <= v_d;
         wait_q      <= wait_d;
         round_q     <= round_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         upd_voice_q <= upd_voice_d;
         upd_freq_q  <= upd_freq_d;
         x_q         <= x_d;
         r_q         <= r_d;
      end
   end

   // Next-state, tick bookkeeping, r sweep and strobes.
   always_comb begin
      state_d     = state_q;
      v_d         = v_q;
      wait_d      = wait_q;
      round_d     = round_q;
      pending_d   = pending_q;
      overrun_d   = overrun_q;
      upd_voice_d = upd_voice_q;
      upd_freq_d  = upd_freq_q;
      x_d         = x_q;
      r_d         = r_q;
      cap         = map_next_x;
      r_inc       = '0;
      map_valid   = 1'b0;
      upd_valid   = 1'b0;
      busy        = 1'b1;

      // At most one tick is ever remembered; a second one is flagged.
      if (tick && pending_q) begin
         overrun_d = 1'b1;
      end
      if (tick && (state_q != StIdle)) begin
         pending_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (tick || pending_q) begin
               pending_d = 1'b0;
               v_d       = '0;
               state_d   = StIssue;
            end
         end
         StIssue: begin
            map_valid = 1'b1;
            wait_d    = '0;
            state_d   = StWait;
         end
         StWait: begin
            if (wait_q == W_LAST) begin
`ifdef LOGS_SCHED_RESEED_EN
               // Keep voices off the x=0 fixed point.
               if (map_next_x == '0) begin
                  cap = X_INIT;
               end
`endif
               x_d[v_q]    = cap;
               upd_freq_d  = cap;
               upd_voice_d = v_q;
               state_d     = StOffer;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         StOffer: begin
            upd_valid = 1'b1;
            if (upd_ready) begin
               if (v_q == V_LAST) begin
                  state_d = StIdle;
                  if (round_q == R_LAST) begin
                     round_d = '0;
                     for (int unsigned i = 0; i < N_VOICE; i++) begin
                        r_inc  = {1'b0, r_q[i]} + 1'b1;
                        r_d[i] = (r_inc >= R_LIMIT) ? INITIAL_R : r_inc[RVW-1:0];
                     end
                  end else begin
                     round_d = round_q + 1'b1;
                  end
               end else begin
                  v_d     = v_q + 1'b1;
                  state_d = StIssue;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign map_x     = x_q[v_q];
   assign map_r     = r_q[v_q];
   assign upd_voice = upd_voice_q;
   assign upd_freq  = upd_freq_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_logs_map_sched.sv
// tb_logs_map_sched: directed self-checking bench for logs_map_sched with a 2-cycle
// logistic-map iterator model (1-x taken as the bitwise complement of x).
module tb_logs_map_sched;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic       upd_ready = 1'b1;
   logic       map_valid, upd_valid, busy, overrun;
   logic [7:0] map_x, map_next_x, upd_freq;
   logic [9:0] map_r;
   logic [1:0] upd_voice;

   int total = 0;
   int bad = 0;

   logic [7:0] exp_x [4];
   logic [9:0] exp_r [4];
   int         rounds_done;

   logic [7:0] pipe0 = 8'h00;
   logic [7:0] pipe1 = 8'h00;
   int         issue_idx = 0;
   bit         zero_v1 = 1'b0;

`ifdef LOGS_SCHED_RESEED_EN
   localparam logic [7:0] ZERO_EXP = 8'h10;
`else
   localparam logic [7:0] ZERO_EXP = 8'h00;
`endif

   logs_map_sched #(
      .N_VOICE      (4),
      .FRAC         (8),
      .TICK_DIV     (32),
      .MAP_LAT      (2),
      .R_STEP_ROUNDS(2),
      .R_SPREAD     (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .map_valid (map_valid),
      .map_x     (map_x),
      .map_r     (map_r),
      .map_next_x(map_next_x),
      .upd_valid (upd_valid),
      .upd_ready (upd_ready),
      .upd_voice (upd_voice),
      .upd_freq  (upd_freq),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] lmap(input logic [7:0] x, input logic [9:0] r);
      logic [7:0]  nx;
      logic [15:0] t;
      logic [17:0] p;
      nx = ~x;
      t  = {8'd0, x} * {8'd0, nx};
      p  = {8'd0, r} * {10'd0, t[15:8]};
      return p[15:8];
   endfunction

   // Iterator model: result appears two clocks after the issue strobe.
   always @(posedge clk) begin
      if (!busy) issue_idx <= 0;
      else if (map_valid) issue_idx <= issue_idx + 1;
      if (map_valid) pipe0 <= (zero_v1 && issue_idx == 1) ? 8'h00 : lmap(map_x, map_r);
      else pipe0 <= 8'hA5;
      pipe1 <= pipe0;
   end
   assign map_next_x = pipe1;

   task automatic model_reset();
      for (int v = 0; v < 4; v++) begin
         exp_x[v] = 8'h10;
         exp_r[v] = 10'(10'h110 + 16 * v);
      end
      rounds_done = 0;
   endtask

   task automatic model_voice(input int v, input bit zero, output logic [7:0] f);
      logic [7:0] raw;
      raw = zero ? 8'h00 : lmap(exp_x[v], exp_r[v]);
`ifdef LOGS_SCHED_RESEED_EN
      if (raw == 8'h00) raw = 8'h10;
`endif
      exp_x[v] = raw;
      f = raw;
   endtask

   task automatic model_round_done();
      int nr;
      rounds_done++;
      if (rounds_done == 2) begin
         rounds_done = 0;
         for (int v = 0; v < 4; v++) begin
            nr = int'(exp_r[v]) + 1;
            exp_r[v] = (nr >= 'h400) ? 10'h110 : 10'(nr);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      total++; if (map_valid !== 1'b0) begin bad++; $display("FAIL rst_map_valid got=%b exp=0", map_valid); end
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL rst_upd_valid got=%b exp=0", upd_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
      total++; if (upd_voice !== 2'd0) begin bad++; $display("FAIL rst_upd_voice got=%0d exp=0", upd_voice); end
      total++; if (map_x !== 8'h10) begin bad++; $display("FAIL rst_map_x got=%h exp=10", map_x); end
      total++; if (map_r !== 10'h110) begin bad++; $display("FAIL rst_map_r got=%h exp=110", map_r); end
      total++; if (upd_freq !== 8'h10) begin bad++; $display("FAIL rst_upd_freq got=%h exp=10", upd_freq); end
      reset = 1'b0;
   endtask

   task automatic test_first_round();
      logic [9:0] r_tab [4] = '{10'h110, 10'h120, 10'h130, 10'h140};
      logic [7:0] f_tab [4] = '{8'h0E, 8'h0F, 8'h10, 8'h11};
      logic [7:0] f;
      int v;
      upd_ready = 1'b1;
      for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_start busy=%b exp=1", busy); end
      for (int c = 0; c <= 16; c++) begin
         v = c / 4;
         total++; if (busy !== (c < 16)) begin bad++; $display("FAIL first_busy c=%0d got=%b", c, busy); end
         total++;
         if (map_valid !== (c % 4 == 0 && c < 16)) begin
            bad++; $display("FAIL first_map_valid c=%0d got=%b", c, map_valid);
         end
         total++;
         if (upd_valid !== (c % 4 == 3 && c < 16)) begin
            bad++; $display("FAIL first_upd_valid c=%0d got=%b", c, upd_valid);
         end
         if (c < 16 && c % 4 == 0) begin
            total++;
            if (map_r !== r_tab[v]) begin
               bad++; $display("FAIL first_map_r v=%0d got=%h exp=%h", v, map_r, r_tab[v]);
            end
            total++;
            if (map_x !== 8'h10) begin bad++; $display("FAIL first_map_x v=%0d got=%h exp=10", v, map_x); end
         end
         if (c < 16 && c % 4 == 3) begin
            model_voice(v, 1'b0, f);
            total++;
            if (upd_voice !== v[1:0] || upd_freq !== f_tab[v]) begin
               bad++; $display("FAIL first_upd v=%0d got=%0d/%h exp=%0d/%h", v, upd_voice, upd_freq, v, f_tab[v]);
            end
         end
         @(negedge clk);
      end
      model_round_done();
   endtask

   task automatic test_backpressure();
      logic [7:0] f, f2;
      int v = 0, hold = 0;
      bit exp_mv = 1'b0;
      upd_ready = 1'b1;
      for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
      for (int c = 0; c < 80 && v < 4; c++) begin
         if (exp_mv) begin
            total++; if (map_valid !== 1'b1) begin bad++; $display("FAIL bp_reissue got=%b exp=1", map_valid); end
            exp_mv = 1'b0;
         end
         if (map_valid) begin
            total++;
            if (map_r !== exp_r[v]) begin bad++; $display("FAIL bp_map_r v=%0d got=%h exp=%h", v, map_r, exp_r[v]); end
         end
         if (upd_valid) begin
            if (v == 2 && hold < 10) begin
               upd_ready = 1'b0;
               if (hold == 0) model_voice(2, 1'b0, f2);
               total++;
               if (upd_voice !== 2'd2 || upd_freq !== f2) begin
                  bad++; $display("FAIL bp_hold h=%0d got=%0d/%h exp=2/%h", hold, upd_voice, upd_freq, f2);
               end
               total++; if (map_valid !== 1'b0) begin bad++; $display("FAIL bp_no_issue h=%0d got=%b", hold, map_valid); end
               hold++;
            end else begin
               upd_ready = 1'b1;
               if (v == 2) begin f = f2; exp_mv = 1'b1; end
               else model_voice(v, 1'b0, f);
               total++;
               if (upd_voice !== v[1:0] || upd_freq !== f) begin
                  bad++; $display("FAIL bp_upd v=%0d got=%0d/%h exp=%0d/%h", v, upd_voice, upd_freq, v, f);
               end
               v++;
            end
         end
         @(negedge clk);
      end
      total++; if (v != 4 || hold != 10) begin bad++; $display("FAIL bp_round got=%0d/%0d exp=4/10", v, hold); end
      model_round_done();
   endtask

   task automatic test_r_sweep();
      logic [7:0]  f;
      logic [39:0] rv;
      int v;
      upd_ready = 1'b1;
      for (int rr = 0; rr < 5; rr++) begin
         if (rr == 2) begin
            rv = {10'h3FF, exp_r[2], exp_r[1], exp_r[0]};
            force dut.r_q = rv;
            @(negedge clk);
            release dut.r_q;
            exp_r[3] = 10'h3FF;
         end
         for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
         v = 0;
         for (int c = 0; c < 40 && v < 4; c++) begin
            if (map_valid) begin
               total++;
               if (map_r !== exp_r[v]) begin
                  bad++; $display("FAIL rs_map_r rr=%0d v=%0d got=%h exp=%h", rr, v, map_r, exp_r[v]);
               end
               if ((rr == 0 && v == 0 && map_r !== 10'h111) || (rr == 2 && v == 0 && map_r !== 10'h112) ||
                   (rr == 2 && v == 3 && map_r !== 10'h3FF) || (rr == 4 && v == 3 && map_r !== 10'h110)) begin
                  bad++; $display("FAIL rs_point rr=%0d v=%0d got=%h", rr, v, map_r);
               end
            end
            if (upd_valid) begin
               model_voice(v, 1'b0, f);
               total++;
               if (upd_freq !== f) begin
                  bad++; $display("FAIL rs_freq rr=%0d v=%0d got=%h exp=%h", rr, v, upd_freq, f);
               end
               v++;
            end
            @(negedge clk);
         end
         total++; if (v != 4) begin bad++; $display("FAIL rs_round rr=%0d got=%0d exp=4", rr, v); end
         model_round_done();
      end
   endtask

   task automatic test_reseed();
      logic [7:0] f;
      int v = 0;
      upd_ready = 1'b1;
      zero_v1 = 1'b1;
      for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
      for (int c = 0; c < 40 && v < 4; c++) begin
         if (upd_valid) begin
            model_voice(v, v == 1, f);
            total++;
            if (upd_freq !== f) begin bad++; $display("FAIL rz_freq v=%0d got=%h exp=%h", v, upd_freq, f); end
            if (v == 1) begin
               total++;
               if (upd_freq !== ZERO_EXP) begin
                  bad++; $display("FAIL rz_zero got=%h exp=%h", upd_freq, ZERO_EXP);
               end
            end
            v++;
         end
         @(negedge clk);
      end
      zero_v1 = 1'b0;
      total++; if (v != 4) begin bad++; $display("FAIL rz_round got=%0d exp=4", v); end
      model_round_done();
   endtask

   task automatic test_overrun();
      upd_ready = 1'b0;
      for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
      for (int c = 0; c < 70; c++) begin
         if (c == 50) begin
            total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ov_early got=%b exp=0", overrun); end
            total++;
            if (upd_valid !== 1'b1 || upd_voice !== 2'd0) begin
               bad++; $display("FAIL ov_stall got=%b/%0d exp=1/0", upd_valid, upd_voice);
            end
         end
         if (c == 66) begin
            total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ov_set got=%b exp=1", overrun); end
         end
         @(negedge clk);
      end
      upd_ready = 1'b1;
      for (int i = 0; i < 30 && busy; i++) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ov_end busy=%b exp=0", busy); end
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || map_valid !== 1'b1) begin
         bad++; $display("FAIL ov_pending_restart got=%b/%b exp=1/1", busy, map_valid);
      end
      for (int i = 0; i < 30 && busy; i++) @(negedge clk);
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ov_sticky got=%b exp=1", overrun); end
   endtask

   task automatic test_async_reset();
      bit seen = 1'b0;
      upd_ready = 1'b1;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (map_valid) seen = 1'b1;
         else @(negedge clk);
      end
      total++; if (!seen) begin bad++; $display("FAIL ar_issue got=0 exp=1"); end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      total++;
      if (upd_valid !== 1'b0 || busy !== 1'b0 || map_valid !== 1'b0) begin
         bad++; $display("FAIL ar_clear got=%b/%b/%b exp=0/0/0", upd_valid, busy, map_valid);
      end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ar_overrun got=%b exp=0", overrun); end
      total++; if (map_x !== 8'h10) begin bad++; $display("FAIL ar_map_x got=%h exp=10", map_x); end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
      total++;
      if (map_valid !== 1'b1 || map_x !== 8'h10 || map_r !== 10'h110) begin
         bad++; $display("FAIL ar_restart got=%b/%h/%h exp=1/10/110", map_valid, map_x, map_r);
      end
      repeat (3) @(negedge clk);
      total++;
      if (upd_valid !== 1'b1 || upd_voice !== 2'd0 || upd_freq !== 8'h0E) begin
         bad++; $display("FAIL ar_first_upd got=%b/%0d/%h exp=1/0/0e", upd_valid, upd_voice, upd_freq);
      end
   endtask

   initial begin
      test_reset();
      test_first_round();
      test_backpressure();
      test_r_sweep();
      test_reseed();
      test_overrun();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
